// File: rtl/wide_adder_seq_if.sv
// wide_adder_seq_if -- request/response bundle for wide_adder_seq.
//   Request : in_valid, in_ready, A, B, cin
//   Response: out_valid, out_ready, S, cout (+ ovf when WIDE_ADDER_SEQ_OVF_EN)
//   master : the requester/consumer side (testbench or upstream logic)
//   slave  : the adder itself
// Optional macro: WIDE_ADDER_SEQ_OVF_EN adds the ovf signal.
interface wide_adder_seq_if #(
    parameter int W = 68
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
`ifdef WIDE_ADDER_SEQ_OVF_EN
    logic         ovf;

    modport master (output in_valid, A, B, cin, out_ready,
                    input  in_ready, out_valid, S, cout, ovf);
    modport slave  (input  in_valid, A, B, cin, out_ready,
                    output in_ready, out_valid, S, cout, ovf);
`else
    modport master (output in_valid, A, B, cin, out_ready,
                    input  in_ready, out_valid, S, cout);
    modport slave  (input  in_valid, A, B, cin, out_ready,
                    output in_ready, out_valid, S, cout);
`endif
endinterface

// File: rtl/wide_adder_seq.sv
// wide_adder_seq -- W = width*CHUNKS bit adder that reuses one width-bit
// Sklansky prefix adder, one chunk per cycle, LSB chunk first.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : wide_adder_seq_if.slave (in_valid/in_ready/A/B/cin request,
//         out_valid/out_ready/S/cout response)
// Accept edge -> CHUNKS RUN edges -> DONE held until out_ready.
// Optional macro: WIDE_ADDER_SEQ_OVF_EN adds the signed-overflow flag ovf.

// Sklansky parallel-prefix adder. cin is folded in as an extra prefix
// position 0 (generate=cin, propagate=0), so after the tree g[i] is the
// carry into bit i and g[width] is the carry out.
module PPA_Sklansky_17bit #(
    parameter int width = 17
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);
    localparam int M  = width + 1;
    localparam int LV = $clog2(M);

    logic [M-1:0] g, p;

    // In-place update is safe: the partner index j never has bit l set,
    // so it is not modified on the same level.
    always_comb begin
        g = {a & b, cin};
        p = {a ^ b, 1'b0};
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < M; i++) begin
                if (((i >> l) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
                    p[i] = p[i] & p[((i >> l) << l) - 1];
                end
            end
        end
    end

    assign sum  = (a ^ b) ^ g[width-1:0];
    assign cout = g[M-1];
endmodule

module wide_adder_seq #(
    parameter int width  = 17,
    parameter int CHUNKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    wide_adder_seq_if.slave  bus
);
    localparam int W  = width * CHUNKS;
    localparam int KW = $clog2(CHUNKS) + 1;  // holds CHUNKS without wrapping
    localparam logic [W-1:0] CMASK = {W{1'b1}} >> (W - width);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q, acc_q, acc_nxt, s_q;
    logic            cin_q, carry_q, cout_q;
    logic [KW-1:0]   k_q;
    int              sh;
    logic [width-1:0] a_chunk, b_chunk, sum_chunk;
    logic            c_in_chunk, c_out_chunk, last_chunk;
`ifdef WIDE_ADDER_SEQ_OVF_EN
    logic            ovf_q;
`endif

    assign sh         = int'(k_q) * width;
    assign a_chunk    = width'(a_q >> sh);
    assign b_chunk    = width'(b_q >> sh);
    assign c_in_chunk = (k_q == '0) ? cin_q : carry_q;
    assign last_chunk = (k_q == KW'(CHUNKS - 1));

    PPA_Sklansky_17bit #(.width(width)) u_add (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (c_in_chunk),
        .sum  (sum_chunk),
        .cout (c_out_chunk)
    );

    // Partial sums build up in acc_q so that S only changes on entry to DONE.
    assign acc_nxt = (acc_q & ~(CMASK << sh)) | (W'(sum_chunk) << sh);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_chunk)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef WIDE_ADDER_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.A;
                    b_q   <= bus.B;
                    cin_q <= bus.cin;
                    k_q   <= '0;
                end
                RUN: begin
                    acc_q   <= acc_nxt;
                    carry_q <= c_out_chunk;
                    k_q     <= k_q + KW'(1);
                    if (last_chunk) begin
                        s_q    <= acc_nxt;
                        cout_q <= c_out_chunk;
`ifdef WIDE_ADDER_SEQ_OVF_EN
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (acc_nxt[W-1] != a_q[W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.S         = s_q;
    assign bus.cout      = cout_q;
`ifdef WIDE_ADDER_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq -- directed checks of wide_adder_seq (width=17, CHUNKS=4)
// plus a CHUNKS=1 instance. Latency is counted in rising edges including the
// accepting edge, so out_valid is seen after edge CHUNKS+1.
module tb_wide_adder_seq;
    localparam int WIDTH  = 17;
    localparam int CHUNKS = 4;
    localparam int W      = WIDTH * CHUNKS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wide_adder_seq_if #(.W(W))  bus  ();
    wide_adder_seq_if #(.W(17)) bus1 ();

    wide_adder_seq #(.width(WIDTH), .CHUNKS(CHUNKS)) dut  (.clk(clk), .rst(rst), .bus(bus));
    wide_adder_seq #(.width(17),    .CHUNKS(1))      dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the main instance and wait for out_valid.
    // While busy, in_ready must be 0 and S must still show prev_s.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] prev_s, output int lat);
        bus.A = a; bus.B = b; bus.cin = c; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            chk("busy_in_ready", 128'(bus.in_ready), 128'(0));
            chk("run_S_hold", 128'(bus.S), 128'(prev_s));
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, acc_cyc, prev_acc;
        logic [W-1:0] a, b, last_s;
        logic         c;
        logic [W:0]   e;
        logic [95:0]  r;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
        step(); step();

        // reset state
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_S",         128'(bus.S),         128'(0));
        chk("rst_cout",      128'(bus.cout),      128'(0));
        chk("rst1_in_ready", 128'(bus1.in_ready), 128'(1));
        chk("rst1_S",        128'(bus1.S),        128'(0));
`ifdef WIDE_ADDER_SEQ_OVF_EN
        chk("rst_ovf",       128'(bus.ovf),       128'(0));
`endif
        rst = 1'b0;

        // carry ripple through every chunk, then backpressure in DONE
        bus.out_ready = 1'b0;
        issue(68'hF_FFFF_FFFF_FFFF_FFFF, 68'h0, 1'b1, 68'h0, lat);
        chk("ripple_lat",  128'(lat),      128'(5));
        chk("ripple_S",    128'(bus.S),    128'(0));
        chk("ripple_cout", 128'(bus.cout), 128'(1));
        bus.in_valid = 1'b1; bus.A = 68'h5; bus.B = 68'h7;   // must be ignored in DONE
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_S",         128'(bus.S),         128'(0));
            chk("bp_cout",      128'(bus.cout),      128'(1));
            chk("bp_in_ready",  128'(bus.in_ready),  128'(0));
        end
        bus.out_ready = 1'b1;
        step();   // DONE -> IDLE; the pending in_valid is not taken on this edge
        bus.in_valid = 1'b0;
        chk("bp_rel_out_valid", 128'(bus.out_valid), 128'(0));
        chk("bp_rel_in_ready",  128'(bus.in_ready),  128'(1));
        step();
        chk("bp_no_accept",     128'(bus.in_ready),  128'(1));

        // reset on the second RUN cycle, with in_valid asserted alongside
        bus.A = 68'd123; bus.B = 68'd456; bus.cin = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.A = 68'd5; bus.B = 68'd7; bus.cin = 1'b0;
        step();
        chk("mrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mrst_S",         128'(bus.S),         128'(0));
        chk("mrst_cout",      128'(bus.cout),      128'(0));
        chk("mrst_in_ready",  128'(bus.in_ready),  128'(1));
        rst = 1'b0;
        step();   // first edge after rst falls accepts
        bus.in_valid = 1'b0;
        chk("mrst_accept", 128'(bus.in_ready), 128'(0));
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("mrst_lat",  128'(lat),      128'(5));
        chk("mrst_S12",  128'(bus.S),    128'(12));
        chk("mrst_cout0",128'(bus.cout), 128'(0));
        step();

        // all ones + all ones + 1
        issue(68'hF_FFFF_FFFF_FFFF_FFFF, 68'hF_FFFF_FFFF_FFFF_FFFF, 1'b1, 68'd12, lat);
        chk("max_lat",  128'(lat),      128'(5));
        chk("max_S",    128'(bus.S),    128'(68'hF_FFFF_FFFF_FFFF_FFFF));
        chk("max_cout", 128'(bus.cout), 128'(1));
        step();

        // carry across the first chunk boundary only
        issue(68'h1FFFF, 68'h1, 1'b0, 68'hF_FFFF_FFFF_FFFF_FFFF, lat);
        chk("bnd_S",    128'(bus.S),    128'(68'h20000));
        chk("bnd_cout", 128'(bus.cout), 128'(0));
        step();
        last_s = 68'h20000;

        // back-to-back random requests; junk operands are driven while busy
        prev_acc = 0;
        for (int n = 0; n < 50; n++) begin
            lat = 0;
            while (!bus.in_ready && lat < 20) begin
                step();
                lat++;
            end
            chk("rnd_ready", 128'(bus.in_ready), 128'(1));
            r = {$urandom(), $urandom(), $urandom()}; a = r[W-1:0];
            r = {$urandom(), $urandom(), $urandom()}; b = r[W-1:0];
            c = 1'($urandom_range(0, 1));
            bus.A = a; bus.B = b; bus.cin = c; bus.in_valid = 1'b1;
            step();
            acc_cyc = cyc;
            if (n > 0) chk("rnd_spacing", 128'(acc_cyc - prev_acc), 128'(6));
            prev_acc = acc_cyc;
            r = {$urandom(), $urandom(), $urandom()}; bus.A = r[W-1:0];
            bus.B = ~b; bus.cin = ~c;
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                chk("rnd_busy_ready", 128'(bus.in_ready), 128'(0));
                chk("rnd_S_hold",     128'(bus.S),        128'(last_s));
                step();
                lat++;
            end
            chk("rnd_done_ready", 128'(bus.in_ready), 128'(0));
            chk("rnd_lat",        128'(lat),          128'(5));
            e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            chk("rnd_sum", 128'({bus.cout, bus.S}), 128'(e));
            last_s = e[W-1:0];
        end
        bus.in_valid = 1'b0;
        step(); step();

`ifdef WIDE_ADDER_SEQ_OVF_EN
        issue(68'h7_FFFF_FFFF_FFFF_FFFF, 68'h1, 1'b0, last_s, lat);
        chk("ovf_S",    128'(bus.S),    128'(68'h8_0000_0000_0000_0000));
        chk("ovf_flag", 128'(bus.ovf),  128'(1));
        chk("ovf_cout", 128'(bus.cout), 128'(0));
        step();
`endif

        // single-chunk instance
        bus1.A = 17'h1FFFF; bus1.B = 17'h1FFFF; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("c1_lat",  128'(lat),       128'(2));
        chk("c1_S",    128'(bus1.S),    128'(17'h1FFFF));
        chk("c1_cout", 128'(bus1.cout), 128'(1));
        step();
        chk("c1_idle", 128'(bus1.in_ready), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
